// File: rtl/fixed_point_addsub_pipe.sv
`default_nettype none
// ============================================================================
// fixed_point_addsub_pipe : 2-stage sign-magnitude adder/subtractor with
//                           saturate/wrap overflow and valid/ready flow control
// Revision: 1.0
// ============================================================================
module fixed_point_addsub_pipe #(
  parameter int WIDTH    = 16,
  parameter bit SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic             ovf,
  output logic             ovf_sticky,
  input  logic             clr_sticky
);

  localparam int MW = WIDTH - 1;

  logic          adv1, adv2;
  logic [MW-1:0] ma, mb;
  logic          sa, sb;

  logic          s1_valid_q, s1_valid_d;
  logic [MW-1:0] s1_big_q, s1_big_d;
  logic [MW-1:0] s1_small_q, s1_small_d;
  logic          s1_sign_q, s1_sign_d;
  logic          s1_add_q, s1_add_d;

  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic             ovf_q, ovf_d;
  logic             ovf_sticky_q, ovf_sticky_d;

  logic [WIDTH-1:0] sum;
  logic [MW-1:0]    diff;
  logic [MW-1:0]    ovf_mag;
  logic [MW-1:0]    mag;
  logic             mag_ovf;

  assign ma = a[MW-1:0];
  assign mb = b[MW-1:0];
  assign sa = a[MW];
  assign sb = b[MW] ^ op;

  assign adv2     = !s2_valid_q || out_ready;
  assign adv1     = !s1_valid_q || adv2;
  assign in_ready = adv1;

  assign sum  = {1'b0, s1_big_q} + {1'b0, s1_small_q};
  assign diff = s1_big_q - s1_small_q;

  generate
    if (SATURATE) begin : g_sat
      assign ovf_mag = '1;
    end else begin : g_wrap
      assign ovf_mag = sum[MW-1:0];
    end
  endgenerate

  // Stage 1: order magnitudes so stage 2 never subtracts into a negative value
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_big_d   = s1_big_q;
    s1_small_d = s1_small_q;
    s1_sign_d  = s1_sign_q;
    s1_add_d   = s1_add_q;
    if (adv1) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_add_d = (sa == sb);
        if ((sa == sb) || (ma >= mb)) begin
          s1_big_d   = ma;
          s1_small_d = mb;
          s1_sign_d  = sa;
        end else begin
          s1_big_d   = mb;
          s1_small_d = ma;
          s1_sign_d  = sb;
        end
      end
    end
  end

  always_comb begin
    mag_ovf = 1'b0;
    mag     = diff;
    if (s1_add_q) begin
      mag_ovf = sum[MW];
      mag     = sum[MW] ? ovf_mag : sum[MW-1:0];
    end
  end

  // Stage 2: a zero magnitude always leaves with a positive sign
  always_comb begin
    s2_valid_d = s2_valid_q;
    c_d        = c_q;
    ovf_d      = ovf_q;
    if (adv2) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        c_d   = {s1_sign_q && (mag != '0), mag};
        ovf_d = mag_ovf;
      end
    end
  end

  always_comb begin
    ovf_sticky_d = ovf_sticky_q;
    if (clr_sticky) begin
      ovf_sticky_d = 1'b0;
    end
    if (s2_valid_q && out_ready && ovf_q) begin
      ovf_sticky_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_big_q     <= '0;
      s1_small_q   <= '0;
      s1_sign_q    <= 1'b0;
      s1_add_q     <= 1'b0;
      s2_valid_q   <= 1'b0;
      c_q          <= '0;
      ovf_q        <= 1'b0;
      ovf_sticky_q <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_big_q     <= s1_big_d;
      s1_small_q   <= s1_small_d;
      s1_sign_q    <= s1_sign_d;
      s1_add_q     <= s1_add_d;
      s2_valid_q   <= s2_valid_d;
      c_q          <= c_d;
      ovf_q        <= ovf_d;
      ovf_sticky_q <= ovf_sticky_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign c          = c_q;
  assign ovf        = ovf_q;
  assign ovf_sticky = ovf_sticky_q;

endmodule
`default_nettype wire

// File: doc/fixed_point_addsub_pipe.md
Name: fixed_point_addsub_pipe

Overview:
Parametrised, pipelined sign-magnitude fixed-point adder/subtractor for the FFT butterfly datapath. It is the successor to the combinational 16-bit sign-magnitude adder and adds:
- configurable word width
- per-transaction add/subtract select
- selectable saturate/wrap overflow handling, with an overflow flag
- a canonical (+0) zero result
- a 2-stage valid/ready pipeline that supports downstream backpressure

Parameters:
WIDTH, 16, total word width; bit WIDTH-1 = sign (1 = negative), bits WIDTH-2:0 = magnitude
SATURATE, 1, 1 = clamp magnitude to all-ones on overflow; 0 = truncate carry (wrap)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  operand pair a/b/op valid
in_ready  out  1  block accepts operands this cycle
a  in  WIDTH  operand A, sign-magnitude
b  in  WIDTH  operand B, sign-magnitude
op  in  1  0 = a+b, 1 = a-b
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result this cycle
c  out  WIDTH  result, sign-magnitude
ovf  out  1  result overflowed magnitude range (qualified by out_valid)
ovf_sticky  out  1  set on any delivered ovf=1 result; cleared only by rst or clr_sticky
clr_sticky  in  1  clears ovf_sticky next cycle (set takes priority if same cycle)

Behaviour:
- One clock domain. Reset is synchronous, active-high. On rst: s1_valid=0, s2_valid=0, c=0, ovf=0, ovf_sticky=0, out_valid=0. Reset mid-operation discards all in-flight data; the next edge resumes normal operation.
- Transfers: input transfer = in_valid & in_ready; output transfer = out_valid & out_ready.
- Advance conditions: adv2 = !s2_valid | out_ready; adv1 = !s1_valid | adv2; in_ready = adv1 (combinational, no dependence on in_valid).
- Stage 1 (registered on input transfer):
  - effective sign sb = b[WIDTH-1] ^ op.
  - compare magnitudes ma = a[WIDTH-2:0] and mb = b[WIDTH-2:0].
  - register big, small, result sign, and an eff_add flag (a sign == sb).
- Stage 2 (registered when adv2 & s1_valid):
  - eff_add: sum = ma+mb at WIDTH bits. Carry out gives ovf=1.
    - SATURATE=1: magnitude = all ones.
    - SATURATE=0: magnitude = low WIDTH-1 bits.
    - Sign = a sign.
  - otherwise: magnitude = big - small; sign = sign of the larger-magnitude operand; ovf=0.
  - any zero result magnitude forces sign=0 (no -0 output). -0 inputs are handled as zero.
- Latency: exactly 2 cycles from input transfer to out_valid with out_ready held high. Throughput is 1 per cycle.
- Backpressure:
  - while out_ready=0 and out_valid=1, c/ovf/out_valid hold stable.
  - with both stages full and out_ready=0, in_ready=0.
  - no result is dropped or duplicated.
  - ordering is preserved.
- If s2 is drained while s1 is empty, out_valid falls next cycle.
- ovf_sticky sets on the edge following an output transfer with ovf=1.

Test Plan:
1. WIDTH=16, out_ready=1: a=0x0005, b=0x8003, op=0 -> after 2 cycles c=0x0002, ovf=0. a=0x0003, b=0x0005, op=1 -> c=0x8002.
2. Equal-magnitude cancel: a=0x8004, b=0x0004 -> c=0x0000 (not 0x8000). a=0x8000, b=0x0000 -> c=0x0000.
3. Overflow: a=0x7FFF, b=0x0001, op=0:
   - SATURATE=1 -> c=0x7FFF, ovf=1, ovf_sticky=1 next cycle.
   - SATURATE=0 -> c=0x0000, ovf=1.
   - a=0xC000, b=0x4000, op=1 -> negative overflow; c=0xFFFF (sat) or 0x8000->0x0000 (wrap, zero sign canonicalised), ovf=1.
4. Backpressure: stream 8 random pairs with in_valid=1, drop out_ready for 3 cycles mid-stream -> in_ready=0 after both stages fill; c held stable; the scoreboard sees all 8 results in order, none lost or duplicated.
5. Reset mid-stream: assert rst for 1 cycle with both stages full -> next cycle out_valid=0, ovf_sticky=0, in_ready=1; subsequent transaction completes with 2-cycle latency.
6. WIDTH=8 sweep: exhaustive a, b, op compared against a sign-magnitude reference model for both SATURATE values; also check clr_sticky and same-cycle set priority.
